// File: rtl/rf_port_arbiter_pkg.sv
// Shared constants and types for the register-file port arbiter.
// Defaults match the 1-bit CPU register file and its three requesters.
package rf_port_arbiter_pkg;

  localparam int RF_REQ_NO     = 3;
  localparam int RF_ADDR_WIDTH = 2;
  localparam int RF_DATA_WIDTH = 1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  // Width of a requester index; never below one bit.
  function automatic int idx_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_port_arbiter_rr_pick.sv
// Rotating-priority selector: first set request at or above ptr, wrapping at N_REQ.
// Purely combinational; returns one-hot sel, binary idx and an any-request flag.
module rr_pick
  import rf_port_arbiter_pkg::*;
#(
  parameter int N_REQ = RF_REQ_NO,
  parameter int IDX_W = idx_bits(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    sel = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        sel[j] = 1'b1;
        idx    = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter for the shared register-file port: one access per
// IDLE -> ACCESS -> DONE pass, writes to the external bank are suppressed.
module rf_port_arbiter
  import rf_port_arbiter_pkg::*;
#(
  parameter int N_REQ      = RF_REQ_NO,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [N_REQ-1:0]             gnt,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         busy,
  output logic [ADDR_WIDTH-1:0]        rf_addr,
  output logic                         rf_wr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  input  logic [DATA_WIDTH-1:0]        rf_rdata
);

  localparam int              IDX_W    = idx_bits(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [N_REQ-1:0]        pick_sel;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    pick_we;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [DATA_WIDTH-1:0]   pick_wdata;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .sel (pick_sel),
    .idx (pick_idx),
    .any (pick_any)
  );

  // One-hot AND-OR mux: slots that are not selected contribute nothing.
  always_comb begin
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_sel[i]) begin
        pick_we    = pick_we    | req_we[i];
        pick_addr  = pick_addr  | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = pick_wdata | req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          win_d   = pick_idx;
          we_d    = pick_we;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        // Sampled before the write lands, so a write returns the old value.
        rdata_d = rf_rdata;
        err_d   = we_q & addr_q[1];
        state_d = ARB_DONE;
      end
      ARB_DONE: begin
        ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    rf_addr  = '0;
    rf_wr    = 1'b0;
    rf_wdata = '0;
    gnt      = '0;
    rsp_err  = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ARB_ACCESS: begin
        rf_addr  = addr_q;
        rf_wdata = wdata_q;
        rf_wr    = we_q & ~addr_q[1];
        busy     = 1'b1;
      end
      ARB_DONE: begin
        gnt     = N_REQ'(1) << win_q;
        rsp_err = err_q;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_rf_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 2;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic [AW-1:0]   rf_addr;
  logic            rf_wr;
  logic [DW-1:0]   rf_wdata;
  logic [DW-1:0]   rf_rdata;

  rf_port_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .rf_addr   (rf_addr),
    .rf_wr     (rf_wr),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata)
  );

  always #5 clk = ~clk;

  // Register file: internal bank is writable, external bank is a read-only mirror.
  logic [DW-1:0] int_mem [2] = '{default: '0};
  logic [DW-1:0] ext_val [2] = '{default: '0};
  assign rf_rdata = rf_addr[1] ? ext_val[rf_addr[0]] : int_mem[rf_addr[0]];
  always @(posedge clk) if (rf_wr && !rf_addr[1]) int_mem[rf_addr[0]] <= rf_wdata;

  // Transaction-level model: one pending access aged 1 (port cycle) then 2 (grant cycle).
  int            m_ptr = 0, m_w = 0, m_age = 0;
  logic          m_busy = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_rd = '0, m_last = '0;
  logic [DW-1:0] m_int [2] = '{default: '0};

  function automatic int pick(input logic [N-1:0] r, input int p);
    int w = -1;
    for (int k = N - 1; k >= 0; k--) if (r[(p + k) % N]) w = (p + k) % N;
    return w;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_age <= 0; m_ptr <= 0; m_rd <= '0; m_last <= '0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_w    <= pick(req, m_ptr);
        m_we   <= req_we[pick(req, m_ptr)];
        m_addr <= req_addr[pick(req, m_ptr)*AW +: AW];
        m_wd   <= req_wdata[pick(req, m_ptr)*DW +: DW];
        m_busy <= 1'b1;
        m_age  <= 1;
      end
    end else if (m_age == 1) begin
      m_rd <= m_addr[1] ? ext_val[m_addr[0]] : m_int[m_addr[0]];
      if (m_we && !m_addr[1]) m_int[m_addr[0]] <= m_wd;
      m_age <= 2;
    end else begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_ptr  <= (m_w + 1) % N;
      m_last <= m_rd;
    end
  end

  int n_chk = 0, n_fail = 0;
  int waitc [N] = '{default: 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic a1, a2;
    logic [N-1:0] eg;
    a1 = m_busy && (m_age == 1);
    a2 = m_busy && (m_age == 2);
    eg = a2 ? (N'(1) << m_w) : '0;
    chk("busy", busy, m_busy);
    chk("rf_wr", rf_wr, a1 && m_we && !m_addr[1]);
    chk("rf_addr", rf_addr, a1 ? m_addr : '0);
    chk("rf_wdata", rf_wdata, a1 ? m_wd : '0);
    chk("gnt", gnt, eg);
    chk("rsp_err", rsp_err, a2 && m_we && m_addr[1]);
    chk("rsp_rdata", rsp_rdata, a2 ? m_rd : m_last);
  endtask

  task automatic fair_upd();
    for (int i = 0; i < N; i++) begin
      if (!rst) waitc[i] = 0;
      else if (gnt[i]) begin
        n_chk++;
        if (waitc[i] > 3 * N) begin
          n_fail++;
          $display("FAIL fairness req%0d: waited %0d cycles, limit %0d", i, waitc[i], 3 * N);
        end
        waitc[i] = 0;
      end else if (req[i]) waitc[i]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmp_model();
    fair_upd();
  endtask

  task automatic post(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
  endtask

  task automatic wait_gnt(input int i, output int lat);
    int  k = 0;
    bit  seen = 1'b0;
    while (!seen && k < 30) begin
      tick();
      k++;
      if (gnt[i]) seen = 1'b1;
    end
    lat = k;
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL gnt_timeout req%0d: no grant after %0d cycles", i, k);
    end
  endtask

  task automatic release_req(input int i);
    tick();
    req[i] = 1'b0;
  endtask

  task automatic run_random(input int cycles);
    logic [N-1:0] drop = '0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      req  = req & ~drop;
      drop = gnt & req;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          req_we[i] = 1'($urandom);
          req_addr[i*AW +: AW] = AW'($urandom);
          req_wdata[i*DW +: DW] = DW'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) ext_val[$urandom_range(0, 1)] = DW'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b0;
        tick();
        rst = 1'b1;
        drop = '0;
      end
    end
  endtask

  initial begin
    int lat, lat2, cyc;
    bit keep0;
    logic [N-1:0] drop_pend;
    int exp_g [4] = '{1, 2, 4, 1};
    int exp_c [4] = '{2, 5, 8, 11};
    int got_g [$];
    int got_c [$];

    // Reset values
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst = 1'b1;
    tick();

    // Single write, then read it back
    post(0, 1'b1, 2'b00, 4'h5);
    tick();
    chk("wr_rf_wr", rf_wr, 1);
    chk("wr_rf_addr", rf_addr, 0);
    chk("wr_rf_wdata", rf_wdata, 4'h5);
    chk("wr_busy", busy, 1);
    tick();
    chk("wr_gnt", gnt, 3'b001);
    chk("wr_err", rsp_err, 0);
    chk("wr_rf_wr_done", rf_wr, 0);
    release_req(0);
    chk("idle_busy", busy, 0);
    post(0, 1'b0, 2'b00, 4'h0);
    wait_gnt(0, lat);
    chk("rd_lat", lat, 2);
    chk("rd_gnt", gnt, 3'b001);
    chk("rd_rdata", rsp_rdata, 4'h5);
    release_req(0);

    // Write returns the pre-write value
    post(1, 1'b1, 2'b00, 4'hA);
    wait_gnt(1, lat);
    chk("prewr_rdata", rsp_rdata, 4'h5);
    chk("prewr_err", rsp_err, 0);
    release_req(1);

    // External write blocked
    post(1, 1'b1, 2'b10, 4'hF);
    tick();
    chk("ext_rf_wr", rf_wr, 0);
    chk("ext_rf_addr", rf_addr, 2);
    tick();
    chk("ext_gnt", gnt, 3'b010);
    chk("ext_err", rsp_err, 1);
    release_req(1);

    // Reset during the port cycle of a write
    post(2, 1'b1, 2'b01, 4'h1);
    tick();
    chk("mid_rf_wr_pre", rf_wr, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rf_wr", rf_wr, 0);
    chk("mid_busy", busy, 0);
    chk("mid_gnt", gnt, 0);
    chk("mid_rf_addr", rf_addr, 0);
    chk("mid_rdata", rsp_rdata, 0);
    req[2] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    post(1, 1'b0, 2'b01, 4'h0);
    post(2, 1'b0, 2'b01, 4'h0);
    wait_gnt(1, lat);
    chk("ptr_rst_lat", lat, 2);
    chk("ptr_rst_gnt", gnt, 3'b010);
    chk("mid_nowrite", rsp_rdata, 0);
    release_req(1);
    wait_gnt(2, lat);
    chk("ptr_rst_gnt2", gnt, 3'b100);
    release_req(2);

    // All three contend from reset; requester 0 keeps requesting after its grant
    rst = 1'b0;
    tick();
    rst = 1'b1;
    post(0, 1'b0, 2'b00, 4'h0);
    post(1, 1'b0, 2'b01, 4'h0);
    post(2, 1'b0, 2'b00, 4'h0);
    keep0 = 1'b1;
    drop_pend = '0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      req = req & ~drop_pend;
      drop_pend = '0;
      if (gnt != '0) begin
        got_g.push_back(int'(gnt));
        got_c.push_back(c);
        drop_pend = gnt;
        if (keep0 && gnt == 3'b001) begin
          drop_pend = '0;
          keep0 = 1'b0;
        end
      end
    end
    req = req & ~drop_pend;
    chk("contend_count", got_g.size(), 4);
    for (int k = 0; k < 4 && k < got_g.size(); k++) begin
      chk("contend_gnt", got_g[k], exp_g[k]);
      chk("contend_cycle", got_c[k], exp_c[k]);
    end

    // Request raised during another requester's grant cycle
    post(0, 1'b0, 2'b01, 4'h0);
    tick();
    tick();
    chk("busyreq_gnt0", gnt, 3'b001);
    post(2, 1'b1, 2'b00, 4'h3);
    tick();
    req[0] = 1'b0;
    wait_gnt(2, lat2);
    cyc = 1 + lat2;
    chk("busyreq_lat", cyc, 3);
    chk("busyreq_gnt", gnt, 3'b100);
    chk("busyreq_rdata", rsp_rdata, 4'hA);
    release_req(2);

    // Read of an external register
    ext_val[1] = 4'h9;
    post(1, 1'b0, 2'b11, 4'h0);
    wait_gnt(1, lat);
    chk("extrd_rdata", rsp_rdata, 4'h9);
    chk("extrd_err", rsp_err, 0);
    release_req(1);
    post(0, 1'b0, 2'b00, 4'h0);
    wait_gnt(0, lat);
    chk("rd00_rdata", rsp_rdata, 4'h3);
    release_req(0);

    run_random(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
